// File: rtl/spi_reg_ctrl.sv
// spi_reg_ctrl: turns SPI slave byte stream into register-file
// writes and read-back bytes with optional address auto-increment.
module spi_reg_ctrl #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              frm_start,
  input  logic              frm_end,
  input  logic              rx_valid,
  input  logic [DATA_W-1:0] rx_data,
  output logic              tx_load,
  output logic [DATA_W-1:0] tx_data,
  output logic              reg_we,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [DATA_W-1:0] reg_wdata,
  input  logic [DATA_W-1:0] reg_rdata,
  output logic              busy,
  output logic [7:0]        err_cnt
);

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    WRITE,
    READ,
    DRAIN
  } state_t;

  state_t state;
  state_t nstate;

  logic inc;
  logic rd_pend;
  logic err_hit;
  logic cmd_load;
  logic wr_sched;
  logic rd_sched;
  logic adv;
  logic cmd_rsv;

  assign cmd_rsv = |rx_data[5:4];
  assign busy    = (state != IDLE);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nstate;
  end

  // Next state and single-cycle action strobes
  always_comb begin
    nstate   = state;
    err_hit  = 1'b0;
    cmd_load = 1'b0;
    wr_sched = 1'b0;
    rd_sched = 1'b0;
    adv      = 1'b0;
    if (frm_start) begin
      nstate = CMD;
    end else begin
      unique case (state)
        IDLE: err_hit = rx_valid;
        CMD: begin
          if (rx_valid) begin
            if (cmd_rsv) begin
              err_hit = 1'b1;
              nstate  = DRAIN;
            end else begin
              cmd_load = 1'b1;
              rd_sched = rx_data[7];
              nstate   = rx_data[7] ? READ : WRITE;
            end
          end else begin
            err_hit = frm_end;
          end
        end
        WRITE: wr_sched = rx_valid;
        READ: begin
          rd_sched = rx_valid;
          adv      = rx_valid & inc;
        end
        DRAIN: begin
        end
        default: nstate = IDLE;
      endcase
      if (frm_end) nstate = IDLE;
    end
  end

  // Write strobe one cycle after the data byte
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_we    <= 1'b0;
      reg_wdata <= '0;
    end else begin
      reg_we <= wr_sched;
      if (wr_sched) reg_wdata <= rx_data;
    end
  end

  // Read data settles one cycle after the address, then loads MISO
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_pend <= 1'b0;
      tx_load <= 1'b0;
      tx_data <= '0;
    end else begin
      rd_pend <= rd_sched;
      tx_load <= rd_pend;
      if (rd_pend) tx_data <= reg_rdata;
    end
  end

  // Address pointer: load on command, step after write or per read
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_addr <= '0;
    end else if (cmd_load) begin
      reg_addr <= rx_data[ADDR_W-1:0];
    end else if (adv || (reg_we && inc)) begin
      reg_addr <= reg_addr + ADDR_W'(1);
    end
  end

  // Auto-increment flag, cleared at every frame start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        inc <= 1'b0;
    else if (frm_start) inc <= 1'b0;
    else if (cmd_load)  inc <= rx_data[6];
  end

  // Saturating protocol error counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= 8'd0;
    end else if (err_hit && (err_cnt != 8'hFF)) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// tb_spi_reg_ctrl: directed and random frames against a
// frame-level model of the SPI register controller.
module tb_spi_reg_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       frm_start = 1'b0;
  logic       frm_end = 1'b0;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       tx_load;
  logic [7:0] tx_data;
  logic       reg_we;
  logic [3:0] reg_addr;
  logic [7:0] reg_wdata;
  logic [7:0] reg_rdata;
  logic       busy;
  logic [7:0] err_cnt;

  logic [7:0] mem [16] = '{default: 8'h00};
  logic [7:0] mdl [16] = '{default: 8'h00};

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int both = 0;
  int e_err = 0;

  int         ow_cyc [$];
  int         ot_cyc [$];
  int         rxc    [$];
  logic [7:0] ow_addr[$];
  logic [7:0] ow_data[$];
  logic [7:0] ot_data[$];
  logic [7:0] ew_addr[$];
  logic [7:0] ew_data[$];
  logic [7:0] et_data[$];

  spi_reg_ctrl #(.ADDR_W(4), .DATA_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .frm_start(frm_start), .frm_end(frm_end),
    .rx_valid(rx_valid), .rx_data(rx_data),
    .tx_load(tx_load), .tx_data(tx_data),
    .reg_we(reg_we), .reg_addr(reg_addr),
    .reg_wdata(reg_wdata), .reg_rdata(reg_rdata),
    .busy(busy), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  assign reg_rdata = mem[reg_addr];

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) if (reg_we) mem[reg_addr] <= reg_wdata;

  always @(negedge clk) begin
    if (reg_we) begin
      ow_cyc.push_back(cyc);
      ow_addr.push_back({4'h0, reg_addr});
      ow_data.push_back(reg_wdata);
    end
    if (tx_load) begin
      ot_cyc.push_back(cyc);
      ot_data.push_back(tx_data);
    end
    if (reg_we && tx_load) both++;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic int sat(input int v);
    return (v > 255) ? 255 : v;
  endfunction

  task automatic clear_obs();
    ow_cyc.delete(); ow_addr.delete(); ow_data.delete();
    ot_cyc.delete(); ot_data.delete(); rxc.delete();
  endtask

  task automatic drive_start();
    @(posedge clk); #1 frm_start = 1'b1;
    @(posedge clk); #1 frm_start = 1'b0;
  endtask

  task automatic drive_end();
    @(posedge clk); #1 frm_end = 1'b1;
    @(posedge clk); #1 frm_end = 1'b0;
  endtask

  task automatic drive_byte(input logic [7:0] b);
    @(posedge clk); #1;
    rx_valid = 1'b1;
    rx_data  = b;
    rxc.push_back(cyc);
    @(posedge clk); #1;
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
    repeat (3) @(posedge clk);
  endtask

  // Frame-level expectation: list of writes, list of returned bytes
  task automatic model_frame(input logic [7:0] cmd,
                             input logic [7:0] b[$]);
    int a;
    ew_addr.delete(); ew_data.delete(); et_data.delete();
    if (cmd[5:4] != 2'b00) begin
      e_err = sat(e_err + 1);
      return;
    end
    a = int'(cmd[3:0]);
    if (cmd[7]) begin
      et_data.push_back(mdl[a]);
      foreach (b[i]) begin
        if (cmd[6]) a = (a + 1) % 16;
        et_data.push_back(mdl[a]);
      end
    end else begin
      foreach (b[i]) begin
        ew_addr.push_back(8'(a));
        ew_data.push_back(b[i]);
        mdl[a] = b[i];
        if (cmd[6]) a = (a + 1) % 16;
      end
    end
  endtask

  task automatic do_frame(input logic [7:0] cmd,
                          input logic [7:0] b[$]);
    clear_obs();
    model_frame(cmd, b);
    drive_start();
    drive_byte(cmd);
    foreach (b[i]) drive_byte(b[i]);
    drive_end();
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if ({reg_we, tx_load, busy} !== 3'b000) begin
      miscompares++;
      $display("FAIL rst_strobes: got %b want 000",
               {reg_we, tx_load, busy});
    end
    vectors++;
    if ({tx_data, reg_wdata} !== 16'h0000) begin
      miscompares++;
      $display("FAIL rst_data: got %h want 0000",
               {tx_data, reg_wdata});
    end
    vectors++;
    if ({reg_addr, err_cnt} !== 12'h000) begin
      miscompares++;
      $display("FAIL rst_addr_err: got %h want 000",
               {reg_addr, err_cnt});
    end
    clear_obs();
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    vectors++;
    if (ow_cyc.size() + ot_cyc.size() != 0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_release: got %0d pulses busy %b want 0 0",
               ow_cyc.size() + ot_cyc.size(), busy);
    end
  endtask

  task automatic test_auto_inc_write();
    logic [7:0] q[$];
    q.push_back(8'hAA);
    q.push_back(8'hBB);
    do_frame(8'h43, q);
    vectors++;
    if (ow_addr.size() != 2 || ot_data.size() != 0) begin
      miscompares++;
      $display("FAIL aiw_count: got w%0d t%0d want w2 t0",
               ow_addr.size(), ot_data.size());
    end else begin
      vectors++;
      if (ow_addr[0] !== 8'h03 || ow_data[0] !== 8'hAA) begin
        miscompares++;
        $display("FAIL aiw_first: got %h/%h want 03/aa",
                 ow_addr[0], ow_data[0]);
      end
      vectors++;
      if (ow_addr[1] !== 8'h04 || ow_data[1] !== 8'hBB) begin
        miscompares++;
        $display("FAIL aiw_second: got %h/%h want 04/bb",
                 ow_addr[1], ow_data[1]);
      end
      vectors++;
      if (ow_cyc[0] - rxc[1] != 1) begin
        miscompares++;
        $display("FAIL aiw_latency: got %0d want 1",
                 ow_cyc[0] - rxc[1]);
      end
    end
    vectors++;
    if (err_cnt !== 8'd0) begin
      miscompares++;
      $display("FAIL aiw_err: got %0d want 0", err_cnt);
    end
  endtask

  task automatic test_read_no_inc();
    logic [7:0] q[$];
    q.push_back(8'h5A);
    do_frame(8'h05, q);
    q.delete();
    q.push_back(8'($urandom));
    q.push_back(8'($urandom));
    do_frame(8'h85, q);
    vectors++;
    if (ot_data.size() != 3 || ow_data.size() != 0) begin
      miscompares++;
      $display("FAIL rd_count: got t%0d w%0d want t3 w0",
               ot_data.size(), ow_data.size());
    end else begin
      foreach (ot_data[i]) begin
        vectors++;
        if (ot_data[i] !== 8'h5A || ot_cyc[i] - rxc[i] != 2) begin
          miscompares++;
          $display("FAIL rd_byte%0d: got %h lat %0d want 5a lat 2",
                   i, ot_data[i], ot_cyc[i] - rxc[i]);
        end
      end
    end
    vectors++;
    if (reg_addr !== 4'h5) begin
      miscompares++;
      $display("FAIL rd_addr: got %h want 5", reg_addr);
    end
  endtask

  task automatic test_wrap();
    logic [7:0] q[$];
    q.push_back(8'h11);
    q.push_back(8'h22);
    do_frame(8'h4F, q);
    vectors++;
    if (ow_addr.size() != 2 || ow_addr[0] !== 8'h0F ||
        ow_addr[1] !== 8'h00) begin
      miscompares++;
      $display("FAIL wrap_write: got n%0d want f,0", ow_addr.size());
    end
    q.delete();
    q.push_back(8'($urandom));
    do_frame(8'hCF, q);
    vectors++;
    if (ot_data.size() != 2 || ot_data[0] !== 8'h11 ||
        ot_data[1] !== 8'h22) begin
      miscompares++;
      $display("FAIL wrap_read: got n%0d want 11,22", ot_data.size());
    end
    vectors++;
    if (err_cnt !== 8'd0) begin
      miscompares++;
      $display("FAIL wrap_err: got %0d want 0", err_cnt);
    end
  endtask

  task automatic test_reserved();
    clear_obs();
    drive_start();
    drive_byte(8'h30);
    drive_byte(8'($urandom));
    drive_byte(8'($urandom));
    #1;
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL rsv_busy: got %b want 1", busy);
    end
    drive_end();
    repeat (2) @(posedge clk);
    #1;
    e_err = sat(e_err + 1);
    vectors++;
    if (err_cnt !== 8'(e_err) || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL rsv_err: got %0d busy %b want %0d busy 0",
               err_cnt, busy, e_err);
    end
    vectors++;
    if (ow_data.size() + ot_data.size() != 0) begin
      miscompares++;
      $display("FAIL rsv_access: got %0d want 0",
               ow_data.size() + ot_data.size());
    end
  endtask

  task automatic test_simultaneous();
    clear_obs();
    drive_start();
    drive_byte(8'h02);
    @(posedge clk); #1;
    rx_valid = 1'b1;
    rx_data  = 8'h77;
    frm_end  = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    frm_end  = 1'b0;
    mdl[2]   = 8'h77;
    vectors++;
    if ({reg_we, reg_addr, reg_wdata, busy} !== {1'b1, 4'h2, 8'h77, 1'b0}) begin
      miscompares++;
      $display("FAIL sim_end: got we%b a%h d%h busy%b want 1 2 77 0",
               reg_we, reg_addr, reg_wdata, busy);
    end
    repeat (2) @(posedge clk);
    clear_obs();
    @(posedge clk); #1;
    frm_start = 1'b1;
    rx_valid  = 1'b1;
    rx_data   = 8'h05;
    @(posedge clk); #1;
    frm_start = 1'b0;
    rx_valid  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (busy !== 1'b1 || err_cnt !== 8'(e_err)) begin
      miscompares++;
      $display("FAIL sim_start: got busy%b err%0d want 1 %0d",
               busy, err_cnt, e_err);
    end
    drive_end();
    repeat (2) @(posedge clk);
    #1;
    e_err = sat(e_err + 1);
    vectors++;
    if (err_cnt !== 8'(e_err) || ow_data.size() != 0) begin
      miscompares++;
      $display("FAIL sim_drop: got err%0d w%0d want %0d 0",
               err_cnt, ow_data.size(), e_err);
    end
  endtask

  task automatic test_random();
    logic [7:0] cmd;
    logic [7:0] q[$];
    int n;
    for (int f = 0; f < 40; f++) begin
      cmd = 8'($urandom);
      if ($urandom_range(4) != 0) cmd[5:4] = 2'b00;
      n = $urandom_range(4);
      q.delete();
      for (int i = 0; i < n; i++) q.push_back(8'($urandom));
      do_frame(cmd, q);
      vectors++;
      if (ow_data.size() != ew_data.size() ||
          ot_data.size() != et_data.size()) begin
        miscompares++;
        $display("FAIL rnd_count f%0d cmd %h: got w%0d t%0d want w%0d t%0d",
                 f, cmd, ow_data.size(), ot_data.size(),
                 ew_data.size(), et_data.size());
      end else begin
        foreach (ew_data[i]) begin
          vectors++;
          if (ow_addr[i] !== ew_addr[i] || ow_data[i] !== ew_data[i] ||
              ow_cyc[i] - rxc[i+1] != 1) begin
            miscompares++;
            $display("FAIL rnd_wr f%0d.%0d: got %h/%h want %h/%h",
                     f, i, ow_addr[i], ow_data[i], ew_addr[i], ew_data[i]);
          end
        end
        foreach (et_data[i]) begin
          vectors++;
          if (ot_data[i] !== et_data[i] || ot_cyc[i] - rxc[i] != 2) begin
            miscompares++;
            $display("FAIL rnd_rd f%0d.%0d: got %h lat %0d want %h lat 2",
                     f, i, ot_data[i], ot_cyc[i] - rxc[i], et_data[i]);
          end
        end
      end
      vectors++;
      if (err_cnt !== 8'(e_err)) begin
        miscompares++;
        $display("FAIL rnd_err f%0d: got %0d want %0d", f, err_cnt, e_err);
      end
    end
    vectors++;
    if (both != 0) begin
      miscompares++;
      $display("FAIL we_and_load: got %0d overlaps want 0", both);
    end
  endtask

  task automatic test_saturate();
    clear_obs();
    for (int i = 0; i < 260; i++) begin
      @(posedge clk); #1;
      rx_valid = 1'b1;
      rx_data  = 8'($urandom);
      @(posedge clk); #1;
      rx_valid = 1'b0;
      if (i == 9) begin
        e_err = sat(e_err + 10);
        #1;
        vectors++;
        if (err_cnt !== 8'(e_err)) begin
          miscompares++;
          $display("FAIL idle_err: got %0d want %0d", err_cnt, e_err);
        end
      end
    end
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (err_cnt !== 8'd255 || ow_data.size() + ot_data.size() != 0) begin
      miscompares++;
      $display("FAIL err_sat: got %0d acc %0d want 255 0",
               err_cnt, ow_data.size() + ot_data.size());
    end
    e_err = 255;
  endtask

  task automatic test_reset_mid();
    drive_start();
    drive_byte(8'h41);
    @(posedge clk); #1;
    rx_valid = 1'b1;
    rx_data  = 8'h9C;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    vectors++;
    if (reg_we !== 1'b1) begin
      miscompares++;
      $display("FAIL rm_pre_we: got %b want 1", reg_we);
    end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({reg_we, tx_load, busy, tx_data, reg_addr, reg_wdata, err_cnt}
        !== 31'h0) begin
      miscompares++;
      $display("FAIL rm_async: got we%b a%h d%h busy%b err%0d want all 0",
               reg_we, reg_addr, reg_wdata, busy, err_cnt);
    end
    e_err = 0;
    repeat (2) @(posedge clk);
    #1;
    clear_obs();
    rst_n = 1'b1;
    drive_byte(8'($urandom));
    drive_byte(8'h41);
    drive_byte(8'($urandom));
    #1;
    e_err = 3;
    vectors++;
    if (err_cnt !== 8'(e_err) || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL rm_after: got err%0d busy%b want 3 0",
               err_cnt, busy);
    end
    vectors++;
    if (ow_data.size() + ot_data.size() != 0) begin
      miscompares++;
      $display("FAIL rm_access: got %0d want 0",
               ow_data.size() + ot_data.size());
    end
  endtask

  initial begin
    test_reset();
    test_auto_inc_write();
    test_read_no_inc();
    test_wrap();
    test_reserved();
    test_simultaneous();
    test_random();
    test_saturate();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
